pinaipple_bus: RTL and testbench



---
 rtl/pinaipple_bus_pkg.sv | 29 ++
 rtl/pinaipple_bus_idfifo.sv | 56 +++++
 rtl/pinaipple_bus.sv | 174 +++++++++++++++++
 tb/tb_pinaipple_bus.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinaipple_bus_pkg.sv
// Shared types, target encoding and default address map
// for the pinaipple bus interconnect.
package pinaipple_bus_pkg;

  typedef enum logic [2:0] {
    HOST_0, HOST_1, HOST_2, HOST_3,
    HOST_4, HOST_5, HOST_6, HOST_7
  } bus_host_e;

  typedef enum logic [3:0] {
    DEV_RAM, DEV_GPIO, DEV_UART, DEV_TIMER
  } bus_device_e;

  // Targets 0..15 are devices; 16 marks an unmapped address.
  localparam int TGT_W = 5;
  localparam logic [TGT_W-1:0] TGT_ERR = 5'd16;

  localparam logic [3:0][31:0] DEF_DEV_BASE = {
    32'h8000_2000, 32'h8000_1000, 32'h8000_0000, 32'h0010_0000
  };
  localparam logic [3:0][31:0] DEF_DEV_MASK = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pinaipple_bus_idfifo.sv
// Per-device FIFO of host IDs awaiting a response,
// oldest at the head.
module pinaipple_bus_idfifo
  import pinaipple_bus_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = idx_w(Depth);
  localparam int CW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [2**PW];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (r_cnt == CW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop) r_rptr <= nxt(r_rptr);
      if (w_push && !w_pop) r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= din_i;
  end

endmodule

// File: rtl/pinaipple_bus.sv
// Multi-host / multi-device bus: address decode, per-device
// round-robin arbitration and in-order response routing.
module pinaipple_bus
  import pinaipple_bus_pkg::*;
#(
  parameter int NumHosts   = 2,
  parameter int NumDevices = 4,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int MaxOutst   = 2,
  parameter logic [NumDevices-1:0][AddrWidth-1:0] DevBase = DEF_DEV_BASE,
  parameter logic [NumDevices-1:0][AddrWidth-1:0] DevMask = DEF_DEV_MASK
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumHosts-1:0]    host_req_i,
  input  logic [NumHosts-1:0]    host_we_i,
  input  logic [AddrWidth-1:0]   host_addr_i  [NumHosts],
  input  logic [DataWidth/8-1:0] host_be_i    [NumHosts],
  input  logic [DataWidth-1:0]   host_wdata_i [NumHosts],
  output logic [NumHosts-1:0]    host_gnt_o,
  output logic [NumHosts-1:0]    host_rvalid_o,
  output logic [NumHosts-1:0]    host_err_o,
  output logic [DataWidth-1:0]   host_rdata_o [NumHosts],
  output logic [NumDevices-1:0]  dev_req_o,
  output logic [NumDevices-1:0]  dev_we_o,
  output logic [AddrWidth-1:0]   dev_addr_o  [NumDevices],
  output logic [DataWidth/8-1:0] dev_be_o    [NumDevices],
  output logic [DataWidth-1:0]   dev_wdata_o [NumDevices],
  input  logic [NumDevices-1:0]  dev_gnt_i,
  input  logic [NumDevices-1:0]  dev_rvalid_i,
  input  logic [NumDevices-1:0]  dev_err_i,
  input  logic [DataWidth-1:0]   dev_rdata_i [NumDevices]
);

  localparam int HW = idx_w(NumHosts);
  localparam int CW = $clog2(MaxOutst + 1);

  logic [TGT_W-1:0]     w_tgt  [NumHosts];
  logic [TGT_W-1:0]     r_last [NumHosts];
  logic [CW-1:0]        r_cnt  [NumHosts];
  logic [NumHosts-1:0]  w_elig;
  logic [NumHosts-1:0]  w_err_gnt;
  logic [NumHosts-1:0]  r_err_pend;
  logic [HW-1:0]        r_ptr  [NumDevices];
  logic [HW-1:0]        w_win  [NumDevices];
  logic [HW-1:0]        w_head [NumDevices];
  logic [NumDevices-1:0] w_full;
  logic [NumDevices-1:0] w_empty;
  logic [NumDevices-1:0] w_hs;
  logic [NumDevices-1:0] w_dresp;

  // A host may only stream to the target it already waits on.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      w_tgt[h] = TGT_ERR;
      for (int d = NumDevices - 1; d >= 0; d--) begin
        if ((host_addr_i[h] & DevMask[d]) == DevBase[d])
          w_tgt[h] = TGT_W'(d);
      end
      w_elig[h] = !rst_i && host_req_i[h] &&
                  ((r_cnt[h] == '0) ||
                   (w_tgt[h] == r_last[h] &&
                    r_cnt[h] < CW'(MaxOutst)));
      w_err_gnt[h] = w_elig[h] && (w_tgt[h] == TGT_ERR);
    end
  end

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    dev_req_o = '0;
    dev_we_o  = '0;
    for (int d = 0; d < NumDevices; d++) begin
      w_win[d]       = '0;
      dev_addr_o[d]  = '0;
      dev_be_o[d]    = '0;
      dev_wdata_o[d] = '0;
      found          = 1'b0;
      for (int k = 0; k < NumHosts; k++) begin
        idx = int'(r_ptr[d]) + k;
        if (idx >= NumHosts) idx = idx - NumHosts;
        if (!found && !w_full[d] && w_elig[idx] &&
            w_tgt[idx] == TGT_W'(d)) begin
          found    = 1'b1;
          w_win[d] = HW'(idx);
        end
      end
      dev_req_o[d] = found;
      if (found) begin
        dev_we_o[d]    = host_we_i[w_win[d]];
        dev_addr_o[d]  = host_addr_i[w_win[d]] & ~DevMask[d];
        dev_be_o[d]    = host_be_i[w_win[d]];
        dev_wdata_o[d] = host_wdata_i[w_win[d]];
      end
    end
  end

  assign w_hs    = dev_req_o & dev_gnt_i;
  assign w_dresp = dev_rvalid_i & ~w_empty & {NumDevices{!rst_i}};

  always_comb begin
    host_gnt_o    = w_err_gnt;
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NumHosts; h++) host_rdata_o[h] = '0;
    for (int d = 0; d < NumDevices; d++) begin
      if (w_hs[d]) host_gnt_o[w_win[d]] = 1'b1;
      if (w_dresp[d]) begin
        host_rvalid_o[w_head[d]] = 1'b1;
        host_err_o[w_head[d]]    = dev_err_i[d];
        host_rdata_o[w_head[d]]  = dev_rdata_i[d];
      end
    end
    for (int h = 0; h < NumHosts; h++) begin
      if (r_err_pend[h]) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_pend <= '0;
      for (int h = 0; h < NumHosts; h++) begin
        r_cnt[h]  <= '0;
        r_last[h] <= TGT_ERR;
      end
      for (int d = 0; d < NumDevices; d++) r_ptr[d] <= '0;
    end else begin
      r_err_pend <= w_err_gnt;
      for (int h = 0; h < NumHosts; h++) begin
        if (host_gnt_o[h]) r_last[h] <= w_tgt[h];
        if (host_gnt_o[h] && !host_rvalid_o[h])
          r_cnt[h] <= r_cnt[h] + CW'(1);
        else if (!host_gnt_o[h] && host_rvalid_o[h])
          r_cnt[h] <= r_cnt[h] - CW'(1);
      end
      for (int d = 0; d < NumDevices; d++) begin
        if (w_hs[d])
          r_ptr[d] <= (w_win[d] == HW'(NumHosts - 1)) ?
                      '0 : w_win[d] + HW'(1);
      end
    end
  end

  for (genvar d = 0; d < NumDevices; d++) begin : g_fifo
    pinaipple_bus_idfifo #(
      .Depth (MaxOutst),
      .Width (HW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_hs[d]),
      .din_i   (w_win[d]),
      .pop_i   (w_dresp[d]),
      .dout_o  (w_head[d]),
      .full_o  (w_full[d]),
      .empty_o (w_empty[d])
    );
  end

  always @(posedge clk_i) begin
    for (int d = 0; d < NumDevices; d++) begin
      if (!rst_i && dev_rvalid_i[d])
        assert (!w_empty[d])
        else $warning("pinaipple_bus: dev %0d rvalid with no id", d);
    end
  end

endmodule

// File: tb/tb_pinaipple_bus.sv
// Directed bench: device models on the bus side, a response
// scoreboard per host, and cycle-level grant checks.
module tb_pinaipple_bus;
  import pinaipple_bus_pkg::*;

  localparam int NH = 2;
  localparam int ND = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  logic [NH-1:0]     host_req, host_we;
  logic [AW-1:0]     host_addr  [NH];
  logic [DW/8-1:0]   host_be    [NH];
  logic [DW-1:0]     host_wdata [NH];
  logic [NH-1:0]     host_gnt, host_rvalid, host_err;
  logic [DW-1:0]     host_rdata [NH];
  logic [ND-1:0]     dev_req, dev_we;
  logic [AW-1:0]     dev_addr  [ND];
  logic [DW/8-1:0]   dev_be    [ND];
  logic [DW-1:0]     dev_wdata [ND];
  logic [ND-1:0]     dev_gnt, dev_rvalid, dev_err;
  logic [DW-1:0]     dev_rdata [ND];

  rsp_t          exp_q [NH][$];
  pend_t         pend  [ND][$];
  int            lat   [ND];
  int            rel   [ND];
  logic [DW-1:0] rd_val [ND];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  pinaipple_bus dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_be_i    (host_be),
    .host_wdata_i (host_wdata),
    .host_gnt_o   (host_gnt),
    .host_rvalid_o(host_rvalid),
    .host_err_o   (host_err),
    .host_rdata_o (host_rdata),
    .dev_req_o    (dev_req),
    .dev_we_o     (dev_we),
    .dev_addr_o   (dev_addr),
    .dev_be_o     (dev_be),
    .dev_wdata_o  (dev_wdata),
    .dev_gnt_i    (dev_gnt),
    .dev_rvalid_i (dev_rvalid),
    .dev_err_i    (dev_err),
    .dev_rdata_i  (dev_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic drive(input int h, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
    host_req[h]   = 1'b1;
    host_we[h]    = we;
    host_addr[h]  = a;
    host_wdata[h] = wd;
    host_be[h]    = '1;
  endtask

  task automatic push(input int h, input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_q[h].push_back(r);
  endtask

  // Device models: capture handshakes, answer after lat cycles,
  // or only when released if lat < 0.
  initial begin
    pend_t p;
    dev_rvalid = '0;
    dev_err    = '0;
    for (int d = 0; d < ND; d++) dev_rdata[d] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (dev_req[d] && dev_gnt[d]) begin
          p.due  = cyc + lat[d];
          p.data = dev_we[d] ? '0 : rd_val[d];
          pend[d].push_back(p);
        end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        dev_rvalid[d] = 1'b0;
        dev_rdata[d]  = '0;
        if (pend[d].size() > 0 &&
            (rel[d] > 0 || (lat[d] >= 0 && pend[d][0].due <= cyc))) begin
          if (rel[d] > 0) rel[d]--;
          dev_rvalid[d] = 1'b1;
          dev_rdata[d]  = pend[d][0].data;
          void'(pend[d].pop_front());
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      for (int h = 0; h < NH; h++) begin
        if (host_rvalid[h]) begin
          if (exp_q[h].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected_h%0d: got rdata %h err %b, expected none",
                     h, host_rdata[h], host_err[h]);
          end else begin
            e = exp_q[h].pop_front();
            check($sformatf("rsp_data_h%0d", h), host_rdata[h], e.data);
            check($sformatf("rsp_err_h%0d", h), 32'(host_err[h]), 32'(e.err));
          end
        end else begin
          check($sformatf("idle_zero_h%0d", h),
                host_rdata[h] | 32'(host_err[h]), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t2_gnt [4];
    logic [31:0] t2_wd [4];
    logic [31:0] t2_off [4];
    t2_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    t2_wd  = '{32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB};
    t2_off = '{32'h100, 32'h200, 32'h100, 32'h200};

    rst      = 1'b1;
    host_req = '0;
    host_we  = '0;
    dev_gnt  = '1;
    for (int h = 0; h < NH; h++) begin
      host_addr[h]  = '0;
      host_be[h]    = '0;
      host_wdata[h] = '0;
    end
    for (int d = 0; d < ND; d++) begin
      lat[d]    = 1;
      rel[d]    = 0;
      rd_val[d] = '0;
    end
    drive(0, 1'b0, 32'h0010_0000, 32'h0);

    // Reset state with a live request on the bus.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(host_gnt), 32'h0);
    check("rst_rvalid", 32'(host_rvalid), 32'h0);
    check("rst_dev_req", 32'(dev_req), 32'h0);
    next();
    rst      = 1'b0;
    host_req = '0;
    @(negedge clk);
    check("idle_dev_req", 32'(dev_req), 32'h0);
    next();

    // GPIO read, one-cycle device.
    rd_val[DEV_GPIO] = 32'hA5;
    drive(0, 1'b0, 32'h8000_0004, 32'h0);
    @(negedge clk);
    check("t1_gnt", 32'(host_gnt), 32'h1);
    check("t1_dev_req", 32'(dev_req), 32'h2);
    check("t1_dev_addr", dev_addr[1], 32'h4);
    check("t1_ram_addr_idle", dev_addr[0], 32'h0);
    push(0, 32'hA5, 1'b0);
    next();
    host_req = '0;
    @(negedge clk);
    check("t1_rvalid", 32'(host_rvalid), 32'h1);
    next();

    // Two hosts writing RAM back to back.
    drive(0, 1'b1, 32'h0010_0100, 32'hAAAA);
    drive(1, 1'b1, 32'h0010_0200, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_gnt%0d", i), 32'(host_gnt), 32'(t2_gnt[i]));
      check($sformatf("t2_wdata%0d", i), dev_wdata[0], t2_wd[i]);
      check($sformatf("t2_addr%0d", i), dev_addr[0], t2_off[i]);
      push(i % 2, 32'h0, 1'b0);
      next();
    end
    host_req = '0;
    idle(2);

    // Unmapped address.
    drive(0, 1'b0, 32'h4000_0000, 32'h0);
    @(negedge clk);
    check("t3_gnt", 32'(host_gnt), 32'h1);
    check("t3_dev_req", 32'(dev_req), 32'h0);
    push(0, 32'h0, 1'b1);
    next();
    host_req = '0;
    @(negedge clk);
    check("t3_rvalid", 32'(host_rvalid), 32'h1);
    check("t3_err", 32'(host_err), 32'h1);
    next();

    // RAM (3 cycles) then UART: UART waits for the RAM response.
    lat[DEV_RAM]     = 3;
    rd_val[DEV_RAM]  = 32'h1234_5678;
    rd_val[DEV_UART] = 32'h55;
    drive(0, 1'b0, 32'h0010_0010, 32'h0);
    @(negedge clk);
    check("t4_ram_gnt", 32'(host_gnt), 32'h1);
    push(0, 32'h1234_5678, 1'b0);
    next();
    drive(0, 1'b0, 32'h8000_1008, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold_gnt%0d", i), 32'(host_gnt), 32'h0);
      check($sformatf("t4_hold_req%0d", i), 32'(dev_req), 32'h0);
      next();
    end
    @(negedge clk);
    check("t4_uart_gnt", 32'(host_gnt), 32'h1);
    check("t4_uart_addr", dev_addr[2], 32'h8);
    push(0, 32'h55, 1'b0);
    next();
    host_req = '0;
    idle(3);

    // Silent RAM: outstanding limit and full-FIFO hold.
    lat[DEV_RAM]    = -1;
    rd_val[DEV_RAM] = 32'hCAFE_0000;
    drive(0, 1'b0, 32'h0010_0000, 32'h0);
    @(negedge clk);
    check("t5_gnt_a", 32'(host_gnt), 32'h1);
    push(0, 32'hCAFE_0000, 1'b0);
    next();
    @(negedge clk);
    check("t5_gnt_b", 32'(host_gnt), 32'h1);
    push(0, 32'hCAFE_0000, 1'b0);
    next();
    @(negedge clk);
    check("t5_block_gnt", 32'(host_gnt), 32'h0);
    check("t5_block_req", 32'(dev_req), 32'h0);
    rel[DEV_RAM] = 1;
    next();
    drive(1, 1'b0, 32'h0010_0008, 32'h0);
    @(negedge clk);
    check("t5_full_pop_gnt", 32'(host_gnt), 32'h0);
    check("t5_full_pop_req", 32'(dev_req), 32'h0);
    next();
    host_req[1] = 1'b0;
    @(negedge clk);
    check("t5_unblock_gnt", 32'(host_gnt), 32'h1);
    push(0, 32'hCAFE_0000, 1'b0);
    next();

    // Reset with two transactions outstanding.
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_gnt", 32'(host_gnt), 32'h0);
    check("t6_rst_req", 32'(dev_req), 32'h0);
    check("t6_rst_rvalid", 32'(host_rvalid), 32'h0);
    exp_q[0].delete();
    next();
    rst      = 1'b0;
    host_req = '0;
    rel[DEV_RAM] = 1;
    next();
    @(negedge clk);
    check("t6_late_rvalid", 32'(host_rvalid), 32'h0);
    pend[DEV_RAM].delete();
    next();
    rd_val[DEV_GPIO] = 32'h77;
    drive(0, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge clk);
    check("t6_post_gnt", 32'(host_gnt), 32'h1);
    push(0, 32'h77, 1'b0);
    next();
    host_req = '0;
    idle(4);

    for (int h = 0; h < NH; h++)
      check($sformatf("final_q_h%0d", h), 32'(exp_q[h].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
